// File: rtl/packer_pkg.sv
// Shared types and width helpers for the nibble result packer.
package packer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // One FIFO entry holds the packed word plus the final carry-out.
    function automatic int entry_width(input int nibbles);
        return 4 * nibbles + 1;
    endfunction

    // A single-nibble word still gets a 1-bit index so no vector is zero-width.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; a push is accepted even when full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);

    // An empty FIFO presents zero so the output port reads 0 right after reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers and count need a
    // known value, and unreset RAM maps onto cheaper memory cells.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/nibble_result_packer.sv
// Packs adder SUM/COUT nibbles, least significant first, into words and queues them
// on a valid/ready port. Input cannot stall, so drops and framing errors are flagged.
module nibble_result_packer
    import packer_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int DEPTH   = 2
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic                 IN_FIRST,
    input  logic [3:0]           SUM,
    input  logic                 COUT,
    input  logic                 OUT_READY,
    output logic                 OUT_VALID,
    output logic [4*NIBBLES-1:0] OUT_DATA,
    output logic                 OUT_CARRY,
    output logic                 OVF,
    output logic                 FRAME_ERR
);

    localparam int WORD_W  = 4 * NIBBLES;
    localparam int ENTRY_W = entry_width(NIBBLES);
    localparam int IW      = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic                ovf_q;
    logic                ferr_q, ferr_d;
    logic                start_word;
    logic                word_done;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so each path has a defined value and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        ferr_d     = ferr_q;
        start_word = 1'b0;
        word_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    if (IN_FIRST) start_word = 1'b1;
                    else          ferr_d     = 1'b1;
                end
            end
            COLLECT: begin
                if (IN_VALID) begin
                    if (IN_FIRST) begin
                        ferr_d     = 1'b1;
                        start_word = 1'b1;
                    end else begin
                        asm_d[{idx_q, 2'b00} +: 4] = SUM;
                        if (idx_q == LAST_IDX) begin
                            word_done = 1'b1;
                            idx_d     = '0;
                            state_d   = IDLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A first nibble always restarts assembly, whether from IDLE or mid-word.
        if (start_word) begin
            asm_d      = '0;
            asm_d[3:0] = SUM;
            if (NIBBLES == 1) begin
                word_done = 1'b1;
                idx_d     = '0;
                state_d   = IDLE;
            end else begin
                idx_d   = IW'(1);
                state_d = COLLECT;
            end
        end
    end

    assign push_entry = {COUT, asm_d};
    assign pop        = ~fifo_empty & OUT_READY;

    always_ff @(posedge CK) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            ferr_q  <= ferr_d;
            // A completed word is only lost when the FIFO is full and nothing leaves.
            ovf_q   <= ovf_q | (word_done & fifo_full & ~pop);
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CK),
        .rst_n   (RST),
        .push_i  (word_done),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign OUT_VALID = ~fifo_empty;
    assign OUT_DATA  = head_entry[WORD_W-1:0];
    assign OUT_CARRY = head_entry[WORD_W];
    assign OVF       = ovf_q;
    assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_nibble_result_packer.sv
// Self-checking bench: directed vector table, hand-written FIFO/reset sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_nibble_result_packer;

    localparam int NIBBLES = 4;
    localparam int DEPTH   = 2;
    localparam int WORD_W  = 4 * NIBBLES;

    logic              CK = 1'b0;
    logic              RST;
    logic              IN_VALID;
    logic              IN_FIRST;
    logic [3:0]        SUM;
    logic              COUT;
    logic              OUT_READY;
    logic              OUT_VALID;
    logic [WORD_W-1:0] OUT_DATA;
    logic              OUT_CARRY;
    logic              OVF;
    logic              FRAME_ERR;

    always #5 CK = ~CK;

    nibble_result_packer #(
        .NIBBLES (NIBBLES),
        .DEPTH   (DEPTH)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_FIRST  (IN_FIRST),
        .SUM       (SUM),
        .COUT      (COUT),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_CARRY (OUT_CARRY),
        .OVF       (OVF),
        .FRAME_ERR (FRAME_ERR)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: partial word as a list of nibbles, FIFO as a queue of words.
    int              m_nibs[$];
    logic [WORD_W:0] m_q[$];
    logic            m_ovf;
    logic            m_ferr;

    task automatic model_edge(input logic rst, input logic v, input logic f,
                              input logic [3:0] s, input logic c, input logic rdy);
        logic [WORD_W-1:0] w;
        if (!rst) begin
            m_nibs.delete();
            m_q.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
            return;
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (v) begin
            if (f) begin
                if (m_nibs.size() > 0) m_ferr = 1'b1;
                m_nibs.delete();
                m_nibs.push_back(int'(s));
            end else if (m_nibs.size() == 0) begin
                m_ferr = 1'b1;
            end else begin
                m_nibs.push_back(int'(s));
            end
        end
        if (m_nibs.size() == NIBBLES) begin
            w = '0;
            for (int k = 0; k < NIBBLES; k++) w = w + (WORD_W'(m_nibs[k]) << (4 * k));
            if (m_q.size() < DEPTH) m_q.push_back({c, w});
            else                    m_ovf = 1'b1;
            m_nibs.delete();
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic f,
                        input logic [3:0] s, input logic c, input logic rdy);
        RST       = rst;
        IN_VALID  = v;
        IN_FIRST  = f;
        SUM       = s;
        COUT      = c;
        OUT_READY = rdy;
        @(posedge CK);
        model_edge(rst, v, f, s, c, rdy);
        @(negedge CK);
    endtask

    task automatic check_model(input string tag);
        logic [WORD_W:0] head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        check({tag, ".valid"}, OUT_VALID, m_q.size() > 0);
        check({tag, ".data"},  OUT_DATA,  head[WORD_W-1:0]);
        check({tag, ".carry"}, OUT_CARRY, head[WORD_W]);
        check({tag, ".ovf"},   OVF,       m_ovf);
        check({tag, ".ferr"},  FRAME_ERR, m_ferr);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input logic c,
                             input logic rdy_body, input logic rdy_last);
        logic last;
        for (int k = 0; k < NIBBLES; k++) begin
            last = (k == NIBBLES - 1);
            step(1'b1, 1'b1, k == 0, w[4*k +: 4], last ? c : 1'b0, last ? rdy_last : rdy_body);
            check_model("word");
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, rdy);
        check_model("idle");
    endtask

    typedef struct {
        logic              rst, v, f;
        logic [3:0]        s;
        logic              c, rdy;
        logic              e_valid;
        logic [WORD_W-1:0] e_data;
        logic              e_carry, e_ovf, e_ferr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic v, input logic f, input logic [3:0] s,
                                input logic c, input logic rdy, input logic ev,
                                input logic [WORD_W-1:0] ed, input logic ec,
                                input logic eo, input logic ef);
        vec_t r;
        r.rst = rst; r.v = v; r.f = f; r.s = s; r.c = c; r.rdy = rdy;
        r.e_valid = ev; r.e_data = ed; r.e_carry = ec; r.e_ovf = eo; r.e_ferr = ef;
        return r;
    endfunction

    initial begin
        RST = 1'b0; IN_VALID = 1'b0; IN_FIRST = 1'b0; SUM = '0; COUT = 1'b0; OUT_READY = 1'b0;
        m_ovf = 1'b0; m_ferr = 1'b0;

        //               rst v  f  sum   c  rdy  valid data      carry ovf ferr
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 1, 4'h5, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 0, 4'hA, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 0, 4'h3, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 0, 4'hC, 1, 1,   1, 16'hC3A5, 1,   0,  0));
        vecs.push_back(mk(1, 0, 0, 4'h0, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 0, 4'h4, 0, 1,   0, 16'h0000, 0,   0,  1));
        vecs.push_back(mk(1, 0, 0, 4'h0, 0, 1,   0, 16'h0000, 0,   0,  1));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 1, 4'h1, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 0, 4'h2, 0, 1,   0, 16'h0000, 0,   0,  0));
        vecs.push_back(mk(1, 1, 1, 4'h7, 0, 1,   0, 16'h0000, 0,   0,  1));
        vecs.push_back(mk(1, 1, 0, 4'h8, 0, 1,   0, 16'h0000, 0,   0,  1));
        vecs.push_back(mk(1, 1, 0, 4'h9, 0, 1,   0, 16'h0000, 0,   0,  1));
        vecs.push_back(mk(1, 1, 0, 4'hA, 0, 1,   1, 16'hA987, 0,   0,  1));
        vecs.push_back(mk(1, 0, 0, 4'h0, 0, 1,   0, 16'h0000, 0,   0,  1));

        @(negedge CK);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].f, vecs[i].s, vecs[i].c, vecs[i].rdy);
            check($sformatf("vec%0d.valid", i), OUT_VALID, vecs[i].e_valid);
            check($sformatf("vec%0d.data", i),  OUT_DATA,  vecs[i].e_data);
            check($sformatf("vec%0d.carry", i), OUT_CARRY, vecs[i].e_carry);
            check($sformatf("vec%0d.ovf", i),   OVF,       vecs[i].e_ovf);
            check($sformatf("vec%0d.ferr", i),  FRAME_ERR, vecs[i].e_ferr);
        end

        // Overflow: three words with the sink stalled; the third is dropped.
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        send_word(16'h4321, 1'b1, 1'b0, 1'b0);
        send_word(16'h8765, 1'b0, 1'b0, 1'b0);
        send_word(16'hCBA9, 1'b1, 1'b0, 1'b0);
        check("ovf.set",   OVF,       1'b1);
        check("ovf.head1", OUT_DATA,  16'h4321);
        check("ovf.carry1", OUT_CARRY, 1'b1);
        idle(1'b1);
        check("ovf.head2", OUT_DATA,  16'h8765);
        check("ovf.carry2", OUT_CARRY, 1'b0);
        idle(1'b1);
        check("ovf.empty", OUT_VALID, 1'b0);
        check("ovf.sticky", OVF,      1'b1);

        // Full FIFO with the last nibble arriving on a pop: nothing is dropped.
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        send_word(16'h1357, 1'b0, 1'b0, 1'b0);
        send_word(16'h2468, 1'b1, 1'b0, 1'b0);
        send_word(16'hFEDC, 1'b1, 1'b0, 1'b1);
        check("fullpop.ovf",  OVF,      1'b0);
        check("fullpop.head", OUT_DATA, 16'h2468);
        idle(1'b1);
        check("fullpop.next", OUT_DATA, 16'hFEDC);
        check("fullpop.ncarry", OUT_CARRY, 1'b1);
        idle(1'b1);
        check("fullpop.empty", OUT_VALID, 1'b0);

        // Reset mid-word with words queued and both flags set.
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
        check_model("stray");
        check("stray.ferr",  FRAME_ERR, 1'b1);
        check("stray.valid", OUT_VALID, 1'b0);
        send_word(16'h0F0F, 1'b0, 1'b0, 1'b0);
        send_word(16'hF0F0, 1'b0, 1'b0, 1'b0);
        send_word(16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'h4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h5, 1'b1, 1'b1);
        check("rst.valid", OUT_VALID, 1'b0);
        check("rst.data",  OUT_DATA,  16'h0000);
        check("rst.ovf",   OVF,       1'b0);
        check("rst.ferr",  FRAME_ERR, 1'b0);
        send_word(16'h5A5A, 1'b1, 1'b1, 1'b1);
        check("post.data",  OUT_DATA,  16'h5A5A);
        check("post.carry", OUT_CARRY, 1'b1);
        idle(1'b1);

        // Randomized traffic against the reference model.
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_v, r_f;
            r_rst = ($urandom % 200) != 0;
            r_v   = ($urandom % 10) < 7;
            r_f   = (m_nibs.size() == 0) ? (($urandom % 10) != 0) : (($urandom % 20) == 0);
            step(r_rst, r_v, r_f, 4'($urandom), 1'($urandom), 1'($urandom));
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_result_packer.md
# nibble_result_packer

Downstream consumer of the 4-bit registered-carry ripple adder. Each cycle it captures one `SUM[3:0]`/`COUT` nibble and packs consecutive nibbles, least significant first, into a full-width result word with its final carry-out. Completed words are buffered in a small FIFO and presented on a valid/ready output port to the result sink. The adder cannot be stalled, so input overflow and framing errors are flagged rather than back-pressured.

## Interface
- `NIBBLES`, default 4: nibbles per word; the output word is 4*NIBBLES bits wide.
- `DEPTH`, default 2: output FIFO entries (≥2, power of 2).
- `CK` in 1: rising-edge clock, shared with the adder.
- `RST` in 1: reset, synchronous, active-low (asserted when 0).
- `IN_VALID` in 1: `SUM`/`COUT` carry a nibble this cycle.
- `IN_FIRST` in 1: qualifies `IN_VALID`; the nibble is nibble 0 of a new word.
- `SUM` in 4: adder sum nibble.
- `COUT` in 1: adder carry-out for this nibble.
- `OUT_READY` in 1: sink accepts the head word.
- `OUT_VALID` out 1: FIFO non-empty.
- `OUT_DATA` out 4*NIBBLES: packed word; nibble k occupies bits [4k+3:4k].
- `OUT_CARRY` out 1: `COUT` of the word's last nibble.
- `OVF` out 1: sticky; a completed word was dropped because the FIFO was full.
- `FRAME_ERR` out 1: sticky; a framing violation occurred.

## Operation
- The collector FSM has two states, IDLE and COLLECT, and a nibble index `idx` of width clog2(NIBBLES).
- IDLE:
  - `IN_VALID & IN_FIRST`: write nibble 0 and set `idx` to 1. Go to COLLECT, or complete immediately if NIBBLES==1.
  - `IN_VALID & ~IN_FIRST`: discard the nibble, set `FRAME_ERR`, stay in IDLE.
- COLLECT:
  - `IN_VALID & ~IN_FIRST`: write the nibble at `idx`. Increment `idx`. When `idx` was NIBBLES-1, the word completes: push {`COUT`, word}, clear `idx`, return to IDLE.
  - `IN_VALID & IN_FIRST`: discard the partial word, set `FRAME_ERR`, and restart with this nibble as nibble 0 (`idx` set to 1).
  - `~IN_VALID`: hold all state. Gaps between nibbles are legal.
- Push on word completion:
  - FIFO not full: the word is written.
  - FIFO full with a pop in the same cycle (`OUT_VALID & OUT_READY`): the push succeeds and occupancy is unchanged.
  - FIFO full with no pop: the word is dropped, `OVF` is set, and FIFO contents are unchanged.
- Pop: occurs on `OUT_VALID & OUT_READY`. `OUT_DATA`/`OUT_CARRY` hold stable while `OUT_VALID & ~OUT_READY`.
- `OVF` and `FRAME_ERR` clear only on reset.
- Pointers wrap modulo DEPTH. Occupancy is tracked by a count register of width clog2(DEPTH)+1.

## Timing
- Reset (`RST`=0 at a `CK` edge) forces: FSM to IDLE, `idx`=0, FIFO empty, `OUT_VALID`=0, `OUT_DATA`=0, `OUT_CARRY`=0, `OVF`=0, `FRAME_ERR`=0.
- Reset overrides all other activity in the same cycle. A partially collected word is lost without flagging.
- Inputs are sampled at the `CK` edge.
- Latency: a word whose last nibble is sampled at edge t has `OUT_VALID`=1 after edge t (visible in cycle t+1) when the FIFO was empty.
- Throughput: one word per NIBBLES cycles sustained, with no bubble between words.
- With `OUT_READY`=1 held, the FIFO never exceeds 1 entry at full input rate.
- All outputs are registered or driven from FIFO storage; there is no combinational path from inputs to outputs.

## Structure
- A shared package `packer_pkg` holds:
  - the FSM state enum (IDLE, COLLECT);
  - the word/entry width helper: entry width = 4*NIBBLES+1.
- One sub-module is natural: `sync_fifo`, parameterized by width and DEPTH, with push/pop/full/empty and simultaneous push+pop when full.
- The collector FSM and assembly register stay in the top module.

## Test plan
- Four nibbles 0x5, 0xA, 0x3, 0xC with `IN_FIRST` on the first, last `COUT`=1, `OUT_READY`=1 -> `OUT_DATA`=0xC3A5, `OUT_CARRY`=1, `OUT_VALID` high for exactly one cycle, one cycle after the last nibble.
- Three back-to-back words, `OUT_READY`=0 -> the first two are stored; the third is dropped and sets `OVF`=1. Then `OUT_READY`=1 -> words 1 and 2 appear in order and `OVF` stays 1.
- FIFO full, with the last nibble of a word arriving in the same cycle as a pop -> no drop, `OVF`=0, occupancy stays 2, and the new word follows.
- Nibbles 0x1, 0x2, then a new `IN_FIRST` nibble 0x7 followed by 0x8, 0x9, 0xA -> `FRAME_ERR`=1 and the only output word is 0xA987.
- A `IN_VALID` nibble without `IN_FIRST` in IDLE -> `FRAME_ERR`=1 and no output. `RST`=0 mid-word with a word queued -> next cycle `OUT_VALID`=0 and both flags 0. A subsequent full word packs correctly.
